// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one data memory between master 0 (CPU load/store port) and
//   master 1 (loader/debug port). At most one access is granted per cycle;
//   the grant is combinational so a single-cycle CPU completes in-cycle.
//   An owner may hold the memory for up to MAX_BURST consecutive cycles
//   while the other master is also requesting. Read data returns to the
//   master that issued the read on the cycle after its grant.
//
// Parameters: AW (address width), DW (data width), MAX_BURST (>=1).
//
// Ports:
//   clk, rst (async, active-low)
//   mK_req/we/addr/wdata  request from master K (K = 0, 1)
//   mK_gnt                access accepted this cycle
//   mK_rvalid/rdata       read return, one cycle after a granted read
//   mem_rvalid/wvalid     dmem strobes
//   mem_addr/wdata        dmem address (shared read/write) and write data
//   mem_rdata             dmem registered read data
//   owner                 registered state: 00 idle, 01 master 0, 10 master 1
//
// Build option: define ARB_ROUND_ROBIN_EN to break ties in favour of the
// master that was not served last; otherwise master 0 has fixed priority.

module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_rvalid,
    output logic          mem_wvalid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    owner
);

    localparam int            CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          gnt_any;
    logic          sel;
    logic          sel_we;
    logic          tie_winner;
    logic          rtag_valid;
    logic          rtag_id;

`ifdef ARB_ROUND_ROBIN_EN
    logic last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= 1'b1;
        end else if (gnt_any) begin
            last <= sel;
        end
    end

    assign tie_winner = ~last;
`else
    // Master 0 wins ties unless it has just used up its burst allowance.
    assign tie_winner = (state == OWN0) && (cnt == CNT_MAX);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Arbitration and next state. Grants are suppressed while reset is held
    // so every output reads zero during reset.
    always_comb begin
        gnt_any   = 1'b0;
        sel       = 1'b0;
        state_nxt = IDLE;
        cnt_nxt   = '0;
        if (rst) begin
            if (state == OWN0 && m0_req && (cnt < CNT_MAX || !m1_req)) begin
                gnt_any = 1'b1;
                sel     = 1'b0;
            end else if (state == OWN1 && m1_req && (cnt < CNT_MAX || !m0_req)) begin
                gnt_any = 1'b1;
                sel     = 1'b1;
            end else if (m0_req && m1_req) begin
                gnt_any = 1'b1;
                sel     = tie_winner;
            end else if (m0_req || m1_req) begin
                gnt_any = 1'b1;
                sel     = m1_req;
            end
        end
        if (gnt_any) begin
            state_nxt = sel ? OWN1 : OWN0;
            if (state_nxt == state) begin
                cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
            end else begin
                cnt_nxt = CW'(1);
            end
        end
    end

    assign m0_gnt     = gnt_any & ~sel;
    assign m1_gnt     = gnt_any & sel;
    assign sel_we     = sel ? m1_we : m0_we;
    assign mem_wvalid = gnt_any & sel_we;
    assign mem_rvalid = gnt_any & ~sel_we;
    assign mem_addr   = gnt_any ? (sel ? m1_addr : m0_addr) : '0;
    assign mem_wdata  = gnt_any ? (sel ? m1_wdata : m0_wdata) : '0;
    assign owner      = state;

    // Read tag: remembers which master owns the data dmem returns next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rtag_valid <= 1'b0;
            rtag_id    <= 1'b0;
        end else begin
            rtag_valid <= gnt_any & ~sel_we;
            rtag_id    <= sel;
        end
    end

    assign m0_rvalid = rtag_valid & ~rtag_id;
    assign m1_rvalid = rtag_valid & rtag_id;
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_rvalid, mem_wvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [1:0]    owner;

    // second instance, MAX_BURST=1, shares all inputs
    logic          a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid;
    logic [DW-1:0] a_m0_rdata, a_m1_rdata;
    logic          a_mem_rvalid, a_mem_wvalid;
    logic [AW-1:0] a_mem_addr;
    logic [DW-1:0] a_mem_wdata;
    logic [DW-1:0] a_mem_rdata = '0;
    logic [1:0]    a_owner;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) u_dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_rvalid(mem_rvalid), .mem_wvalid(mem_wvalid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
    );

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(1)) u_alt (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
        .mem_rvalid(a_mem_rvalid), .mem_wvalid(a_mem_wvalid), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .owner(a_owner)
    );

    // dmem: registered read, write visible to a read on the following cycle
    logic [DW-1:0] dmem [0:63];
    always @(posedge clk) begin
        if (mem_wvalid) dmem[mem_addr[7:2]] <= mem_wdata;
        if (mem_rvalid) mem_rdata <= dmem[mem_addr[7:2]];
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [0:63];
    int            mdl_owner = -1;   // -1 none, else master index
    int            mdl_run   = 0;    // consecutive grants to mdl_owner
    int            mdl_last  = 1;    // last master served
    logic          pend_v    = 1'b0;
    int            pend_k    = 0;
    logic [DW-1:0] pend_d    = '0;

    int            exp_sel   = -1;
    logic          exp_g0 = 1'b0, exp_g1 = 1'b0, exp_mr = 1'b0, exp_mw = 1'b0;
    logic          exp_rv0 = 1'b0, exp_rv1 = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wd = '0, exp_rd0 = '0, exp_rd1 = '0;
    logic [1:0]    exp_owner = 2'b00;

    function automatic int pick(logic r0, logic r1);
        if (!r0 && !r1) return -1;
        if (r0 != r1) return r0 ? 0 : 1;
        if (mdl_owner >= 0 && mdl_run < MB) return mdl_owner;
`ifdef ARB_ROUND_ROBIN_EN
        return 1 - mdl_last;
`else
        return (mdl_owner == 0) ? 1 : 0;
`endif
    endfunction

    task automatic model_reset();
        mdl_owner = -1; mdl_run = 0; mdl_last = 1; pend_v = 1'b0;
        exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_rd0 = '0; exp_rd1 = '0;
        exp_owner = 2'b00;
    endtask

    task automatic predict();
        exp_sel  = rst ? pick(m0_req, m1_req) : -1;
        exp_g0   = (exp_sel == 0);
        exp_g1   = (exp_sel == 1);
        exp_addr = '0; exp_wd = '0; exp_mr = 1'b0; exp_mw = 1'b0;
        if (exp_sel == 0) begin
            exp_addr = m0_addr; exp_wd = m0_wdata; exp_mw = m0_we; exp_mr = !m0_we;
        end else if (exp_sel == 1) begin
            exp_addr = m1_addr; exp_wd = m1_wdata; exp_mw = m1_we; exp_mr = !m1_we;
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input logic r1, input logic w1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        #1;
        predict();
    endtask

    task automatic tick();
        int idx;
        @(posedge clk);
        idx = int'(exp_addr[7:2]);
        if (exp_sel >= 0) begin
            mdl_run   = (exp_sel == mdl_owner) ? ((mdl_run < MB) ? mdl_run + 1 : MB) : 1;
            mdl_owner = exp_sel;
            mdl_last  = exp_sel;
            pend_v    = exp_mr;
            pend_k    = exp_sel;
            pend_d    = ref_mem[idx];
            if (exp_mw) ref_mem[idx] = exp_wd;
        end else begin
            mdl_owner = -1; mdl_run = 0; pend_v = 1'b0;
        end
        #1;
        exp_rv0   = pend_v && (pend_k == 0);
        exp_rv1   = pend_v && (pend_k == 1);
        exp_rd0   = exp_rv0 ? pend_d : '0;
        exp_rd1   = exp_rv1 ? pend_d : '0;
        exp_owner = (mdl_owner == 0) ? 2'b01 : (mdl_owner == 1) ? 2'b10 : 2'b00;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return AW'($urandom_range(0, 63)) << 2;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        #3;
        m0_req = 1'b1; m0_we = 1'b1; m0_wdata = 32'h0BAD_0000;
        rst = 1'b0;
        model_reset();
        #1;
        total++;
        if ({m0_gnt, m1_gnt, mem_rvalid, mem_wvalid, m0_rvalid, m1_rvalid} !== 6'b0) begin
            bad++;
            $display("FAIL reset_strobes got=%b want=000000",
                     {m0_gnt, m1_gnt, mem_rvalid, mem_wvalid, m0_rvalid, m1_rvalid});
        end
        total++;
        if ({mem_addr, mem_wdata, m0_rdata, m1_rdata} !== '0) begin
            bad++;
            $display("FAIL reset_data got=%h %h %h %h want=0", mem_addr, mem_wdata, m0_rdata, m1_rdata);
        end
        total++;
        if (owner !== 2'b00) begin
            bad++; $display("FAIL reset_owner got=%b want=00", owner);
        end
        @(posedge clk); #1;
        total++;
        if ({m0_gnt, owner} !== 3'b000) begin
            bad++; $display("FAIL reset_hold got=%b want=000", {m0_gnt, owner});
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        predict();
        total++;
        if (m0_gnt !== 1'b1 || exp_g0 !== 1'b1) begin
            bad++; $display("FAIL release_gnt got=%b want=1", m0_gnt);
        end
        tick();
        total++;
        if (owner !== 2'b01) begin
            bad++; $display("FAIL release_owner got=%b want=01", owner);
        end
    endtask

    task automatic test_preload();
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, AW'(i) << 2, $urandom);
            total++;
            if ({m1_gnt, m0_gnt, mem_wvalid, mem_rvalid, mem_addr, mem_wdata} !==
                {exp_g1, exp_g0, exp_mw, exp_mr, exp_addr, exp_wd}) begin
                bad++;
                $display("FAIL preload[%0d] got=%b%b %h %h want=%b%b %h %h", i, m1_gnt,
                         mem_wvalid, mem_addr, mem_wdata, exp_g1, exp_mw, exp_addr, exp_wd);
            end
            tick();
        end
    endtask

    task automatic test_single_read();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h10, 32'hCAFE_F00D);
        tick();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h10, '0);
        total++;
        if ({m1_gnt, mem_rvalid, mem_wvalid, mem_addr} !== {1'b1, 1'b1, 1'b0, 32'h10}) begin
            bad++;
            $display("FAIL single_read_issue got=%b%b%b %h want=110 00000010",
                     m1_gnt, mem_rvalid, mem_wvalid, mem_addr);
        end
        tick();
        total++;
        if ({m1_rvalid, m1_rdata, m0_rvalid, m0_rdata} !== {1'b1, 32'hCAFE_F00D, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL single_read_return got=%b %h %b %h want=1 cafef00d 0 0",
                     m1_rvalid, m1_rdata, m0_rvalid, m0_rdata);
        end
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        tick();
        total++;
        if ({m1_rvalid, owner} !== 3'b000) begin
            bad++; $display("FAIL single_read_idle got=%b want=000", {m1_rvalid, owner});
        end
    endtask

    task automatic test_write_then_read();
        drive(1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 1'b0, '0, '0);
        total++;
        if ({m0_gnt, mem_wvalid, mem_wdata} !== {1'b1, 1'b1, 32'h1234_5678}) begin
            bad++; $display("FAIL wr_issue got=%b%b %h want=11 12345678", m0_gnt, mem_wvalid, mem_wdata);
        end
        tick();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h20, '0);
        total++;
        if (m1_gnt !== 1'b1) begin
            bad++; $display("FAIL rd_after_wr_gnt got=%b want=1", m1_gnt);
        end
        tick();
        total++;
        if ({m1_rvalid, m1_rdata} !== {1'b1, 32'h1234_5678} || exp_rd1 !== 32'h1234_5678) begin
            bad++; $display("FAIL rd_after_wr_data got=%b %h want=1 12345678", m1_rvalid, m1_rdata);
        end
    endtask

    task automatic test_burst();
        int streak = 0, max_streak = 0, prev = -1;
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, rand_addr(), '0, 1'b1, 1'b0, rand_addr(), '0);
            total++;
            if ({m0_gnt, m1_gnt} !== {exp_g0, exp_g1}) begin
                bad++; $display("FAIL burst_gnt[%0d] got=%b%b want=%b%b", i, m0_gnt, m1_gnt, exp_g0, exp_g1);
            end
            if (m0_gnt ^ m1_gnt) begin
                streak = (int'(m1_gnt) == prev) ? streak + 1 : 1;
                prev   = int'(m1_gnt);
                if (streak > max_streak) max_streak = streak;
            end
            tick();
            total++;
            if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== {exp_rv0, exp_rv1, exp_rd0, exp_rd1}) begin
                bad++;
                $display("FAIL burst_ret[%0d] got=%b%b %h %h want=%b%b %h %h", i, m0_rvalid, m1_rvalid,
                         m0_rdata, m1_rdata, exp_rv0, exp_rv1, exp_rd0, exp_rd1);
            end
        end
        total++;
        if (max_streak != MB) begin
            bad++; $display("FAIL burst_limit got=%0d want=%0d", max_streak, MB);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rand_addr(), $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, rand_addr(), $urandom);
            total++;
            if ({m0_gnt, m1_gnt, mem_rvalid, mem_wvalid, mem_addr, mem_wdata} !==
                {exp_g0, exp_g1, exp_mr, exp_mw, exp_addr, exp_wd}) begin
                bad++;
                $display("FAIL rand_mem[%0d] got=%b%b%b%b %h %h want=%b%b%b%b %h %h", i, m0_gnt, m1_gnt,
                         mem_rvalid, mem_wvalid, mem_addr, mem_wdata, exp_g0, exp_g1, exp_mr, exp_mw,
                         exp_addr, exp_wd);
            end
            tick();
            total++;
            if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, owner} !==
                {exp_rv0, exp_rv1, exp_rd0, exp_rd1, exp_owner}) begin
                bad++;
                $display("FAIL rand_ret[%0d] got=%b%b %h %h %b want=%b%b %h %h %b", i, m0_rvalid, m1_rvalid,
                         m0_rdata, m1_rdata, owner, exp_rv0, exp_rv1, exp_rd0, exp_rd1, exp_owner);
            end
        end
    endtask

    task automatic test_alternate();
        logic [1:0] want;
        rst = 1'b0;
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        tick();
        model_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, rand_addr(), '0, 1'b1, 1'b0, rand_addr(), '0);
            want = (i % 2 == 0) ? 2'b10 : 2'b01;
            total++;
            if ({a_m0_gnt, a_m1_gnt} !== want) begin
                bad++; $display("FAIL alt_gnt[%0d] got=%b%b want=%b", i, a_m0_gnt, a_m1_gnt, want);
            end
            tick();
        end
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, rand_addr(), '0);
        total++;
        if ({a_m0_gnt, a_m1_gnt} !== 2'b01) begin
            bad++; $display("FAIL alt_solo got=%b%b want=01", a_m0_gnt, a_m1_gnt);
        end
        tick();
        drive(1'b1, 1'b0, rand_addr(), '0, 1'b1, 1'b0, rand_addr(), '0);
        total++;
        if ({a_m0_gnt, a_m1_gnt} !== 2'b10) begin
            bad++; $display("FAIL alt_rejoin got=%b%b want=10", a_m0_gnt, a_m1_gnt);
        end
        tick();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        tick();
    endtask

    task automatic test_reset_mid_read();
        drive(1'b1, 1'b0, 32'h30, '0, 1'b0, 1'b0, '0, '0);
        total++;
        if ({m0_gnt, mem_rvalid} !== 2'b11) begin
            bad++; $display("FAIL midrst_issue got=%b%b want=11", m0_gnt, mem_rvalid);
        end
        #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        total++;
        if (m0_rvalid !== 1'b0) begin
            bad++; $display("FAIL midrst_during got=%b want=0", m0_rvalid);
        end
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        tick();
        total++;
        if ({m0_rvalid, m0_rdata, m1_rvalid} !== {1'b0, 32'h0, 1'b0}) begin
            bad++; $display("FAIL midrst_after got=%b %h %b want=0 0 0", m0_rvalid, m0_rdata, m1_rvalid);
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_single_read();
        test_write_then_read();
        test_burst();
        test_random();
        test_alternate();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
